// File: rtl/nios0_uart_tx_data.sv
// nios0_uart_tx_data: Avalon-MM UART transmitter for the Nios II core.
//   Double-buffered (holding register + shift register), 8N1 framing, a
//   status register and a level interrupt that asserts while the holding
//   register is empty and irq_en is set.
//   Optional feature macro UART_TX_PARITY_EN: adds an even parity bit (8E1)
//   and sets status bit 3.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    Avalon word address (0 data, 1 status/clear, 2 irq_en, 3 reserved)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data, 1-cycle latency from address
//   txd        serial output, idle high
//   irq        level interrupt
module nios0_uart_tx_data #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        irq
);

  localparam logic [15:0] DivM1 = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic ParityCap = 1'b1;
`else
  localparam logic ParityCap = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        overrun_q, overrun_d;
  logic        irq_en_q, irq_en_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;

  logic        load;
  logic        bit_end;
  logic        wr, wr_data, wr_stat, wr_ctrl;
  logic        busy, ready;
  logic [31:0] status;

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:8], par_q};

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == 2'd0);
  assign wr_stat = wr & (address == 2'd1);
  assign wr_ctrl = wr & (address == 2'd2);
  assign busy    = (state_q != StIdle);
  assign ready   = ~hold_full_q;
  assign status  = {28'b0, ParityCap, overrun_q, busy, ready};
  assign bit_end = (cnt_q == 16'd0);

  // Transmit FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StStart;
          cnt_d   = DivM1;
        end
      end
      default: begin
        if (!bit_end) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d = DivM1;
          unique case (state_q)
            StStart: begin
              state_d = StData;
              bit_d   = 3'd0;
            end
            StData: begin
              shift_d = {1'b0, shift_q[7:1]};
              bit_d   = 3'(bit_q + 3'd1);
              if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_d = StParity;
`else
                state_d = StStop;
`endif
              end
            end
            StParity: state_d = StStop;
            default: begin
              // End of stop bit: chain straight into the next frame if queued.
              if (hold_full_q) begin
                load    = 1'b1;
                state_d = StStart;
              end else begin
                state_d = StIdle;
                cnt_d   = 16'd0;
              end
            end
          endcase
        end
      end
    endcase
    if (load) begin
      shift_d = hold_q;
      par_d   = ^hold_q;
    end
  end

  // txd is registered from the next state so it changes only on clock edges.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // Register file
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    irq_en_d    = irq_en_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (wr_stat && writedata[2]) begin
      overrun_d = 1'b0;
    end
    // A load in this cycle frees the holding register, so the write lands.
    // Set is evaluated after clear so set wins.
    if (wr_data) begin
      if (!hold_full_q || load) begin
        hold_d      = writedata[7:0];
        hold_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (wr_ctrl) begin
      irq_en_d = writedata[0];
    end
  end

  always_comb begin
    readdata_d = 32'd0;
    unique case (address)
      2'd1:    readdata_d = status;
      2'd2:    readdata_d = {31'b0, irq_en_q};
      default: readdata_d = 32'd0;
    endcase
  end

  assign irq_d = irq_en_q & ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      txd_q       <= 1'b1;
      irq_q       <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      irq_en_q    <= irq_en_d;
      txd_q       <= txd_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign txd      = txd_q;
  assign irq      = irq_q;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_nios0_uart_tx_data.sv
module tb_nios0_uart_tx_data;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int  FRAME_BITS = 11;
  localparam bit  PAR = 1'b1;
  localparam logic [31:0] STAT_PAR = 32'h8;
`else
  localparam int  FRAME_BITS = 10;
  localparam bit  PAR = 1'b0;
  localparam logic [31:0] STAT_PAR = 32'h0;
`endif
  localparam int FL = FRAME_BITS * CLK_DIV;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        txd;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  nios0_uart_tx_data #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .txd        (txd),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at sample i of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k >= 1 && k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Called at a negedge; drives one write cycle and returns at the next negedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd got %b want 1", txd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
    n_cmp++; if (readdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_readdata got %h want 0", readdata);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL idle_txd got %b want 1", txd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL idle_irq got %b want 0", irq); end
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== (32'h1 | STAT_PAR)) begin
      n_bad++; $display("FAIL idle_status got %h want %h", rd, 32'h1 | STAT_PAR);
    end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL read_addr0 got %h want 0", rd); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL read_irqen got %h want 0", rd); end
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL read_addr3 got %h want 0", rd); end
  endtask

  task automatic test_single_frame;
    bus_write(2'd0, 32'h55);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL start_latency got %b want 1", txd); end
    address = 2'd1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== frame_bit(8'h55, i)) begin
        n_bad++; $display("FAIL frame55 bit %0d got %b want %b", i, txd, frame_bit(8'h55, i));
      end
      if (i == 20) begin
        n_cmp++; if (readdata !== (32'h3 | STAT_PAR)) begin
          n_bad++; $display("FAIL busy_mid got %h want %h", readdata, 32'h3 | STAT_PAR);
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL after55_txd got %b want 1", txd); end
    @(negedge clk);
    n_cmp++; if (readdata !== (32'h1 | STAT_PAR)) begin
      n_bad++; $display("FAIL busy_after got %h want %h", readdata, 32'h1 | STAT_PAR);
    end
  endtask

  task automatic test_back_to_back;
    logic exp;
    bus_write(2'd0, 32'hA3);
    bus_write(2'd0, 32'h0F);
    address = 2'd1;
    for (int i = 0; i <= 2 * FL; i++) begin
      exp = (i < FL) ? frame_bit(8'hA3, i) : frame_bit(8'h0F, i - FL);
      n_cmp++; if (txd !== exp) begin
        n_bad++; $display("FAIL b2b sample %0d got %b want %b", i, txd, exp);
      end
      if (i == 1 || i == FL) begin
        n_cmp++; if (readdata !== (32'h2 | STAT_PAR)) begin
          n_bad++; $display("FAIL b2b_notready %0d got %h want %h", i, readdata, 32'h2 | STAT_PAR);
        end
      end
      if (i == FL + 1) begin
        n_cmp++; if (readdata !== (32'h3 | STAT_PAR)) begin
          n_bad++; $display("FAIL b2b_ready got %h want %h", readdata, 32'h3 | STAT_PAR);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] rd;
    bus_write(2'd0, 32'h11);
    repeat (5) @(negedge clk);
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== (32'h6 | STAT_PAR)) begin
      n_bad++; $display("FAIL overrun_set got %h want %h", rd, 32'h6 | STAT_PAR);
    end
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== (32'h2 | STAT_PAR)) begin
      n_bad++; $display("FAIL overrun_clr got %h want %h", rd, 32'h2 | STAT_PAR);
    end
    repeat (2 * FL) @(negedge clk);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== (32'h1 | STAT_PAR)) begin
      n_bad++; $display("FAIL overrun_drop got %h want %h", rd, 32'h1 | STAT_PAR);
    end
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    bus_write(2'd2, 32'h1);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_enable got %b want 1", irq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL irqen_read got %h want 1", rd); end
    bus_write(2'd0, 32'h00);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_at_write got %b want 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_deassert got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_reassert got %b want 1", irq); end
    repeat (FL + 4) @(negedge clk);
    bus_write(2'd2, 32'h0);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disable got %b want 0", irq); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rd;
    int lows;
    bus_write(2'd0, 32'hF7);
    bus_write(2'd0, 32'h12);
    // Now at frame sample 0; sample 17 lies in data bit 3 (0 for 0xF7).
    repeat (17) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL pre_reset_bit3 got %b want 0", txd); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL async_reset_txd got %b want 1", txd); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== (32'h1 | STAT_PAR)) begin
      n_bad++; $display("FAIL post_reset_status got %h want %h", rd, 32'h1 | STAT_PAR);
    end
    lows = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin
      n_bad++; $display("FAIL residual_frame got %0d low samples want 0", lows);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    bus_write(2'd0, 32'h07);
    for (int i = 0; i <= FL; i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== frame_bit(8'h07, i)) begin
        n_bad++; $display("FAIL parity_frame %0d got %b want %b", i, txd, frame_bit(8'h07, i));
      end
      if (i == 9 * CLK_DIV) begin
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL parity_bit got %b want 1", txd); end
      end
    end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_irq();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
